// File: rtl/hazard_ctrl_v2.sv
// Registered hazard controller for the 5-stage MIPS pipeline: load-use stalls,
// memory-wait freezes, deferred redirects, halt drain and saturating counters.
module hazard_ctrl_v2 #(
   parameter int REG_W        = 5,
   parameter int LU_CYCLES    = 1,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dmem_req,
   input  logic             dhit,
   input  logic             halt_in,
   input  logic             redirect,
   input  logic             ex_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_bubble,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {RUN, LU_STALL, DRAIN, HALTED} state_t;

   state_t             r_state;
   logic [2:0]         r_lu_ctr;
   logic [DRAIN_W-1:0] r_drain_ctr;
   logic               r_redir_pend;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;

   logic w_mem_wait;
   logic w_eff_redir;
   logic w_lu_hit;

   assign w_mem_wait  = dmem_req & ~dhit;
   assign w_eff_redir = redirect | r_redir_pend;
   assign w_lu_hit    = ex_load & (ex_rd != '0) &
                        ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   // Branch order below is the hazard priority; state decides which events are visible.
   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      ifid_flush   = 1'b0;
      idex_en      = 1'b1;
      idex_flush   = 1'b0;
      exmem_en     = 1'b1;
      memwb_bubble = 1'b0;
      halted       = 1'b0;
      if (r_state == HALTED) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         halted   = 1'b1;
      end else if (w_mem_wait) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (r_state == DRAIN) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end else if (w_eff_redir) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (halt_in) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end else if ((r_state == LU_STALL) || w_lu_hit) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (!ihit) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= RUN;
         r_lu_ctr     <= '0;
         r_drain_ctr  <= '0;
         r_redir_pend <= 1'b0;
         r_stall_cnt  <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if ((r_state != HALTED) && !pc_en && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         case (r_state)
            RUN, LU_STALL: begin
               if (w_mem_wait) begin
                  // Redirect cannot be applied while frozen; remember it for the release cycle.
                  if (redirect)
                     r_redir_pend <= 1'b1;
               end else if (w_eff_redir) begin
                  r_redir_pend <= 1'b0;
                  r_state      <= RUN;
                  r_lu_ctr     <= '0;
                  if (r_flush_cnt != '1)
                     r_flush_cnt <= r_flush_cnt + 1'b1;
               end else if (halt_in) begin
                  r_lu_ctr <= '0;
                  if (DRAIN_CYCLES == 0) begin
                     r_state <= HALTED;
                  end else begin
                     r_state     <= DRAIN;
                     r_drain_ctr <= DRAIN_W'(DRAIN_CYCLES);
                  end
               end else if (r_state == LU_STALL) begin
                  r_lu_ctr <= r_lu_ctr - 3'd1;
                  if (r_lu_ctr <= 3'd1)
                     r_state <= RUN;
               end else if (w_lu_hit && (LU_CYCLES > 1)) begin
                  r_state  <= LU_STALL;
                  r_lu_ctr <= 3'(LU_CYCLES - 1);
               end
            end
            DRAIN: begin
               if (!w_mem_wait) begin
                  r_drain_ctr <= r_drain_ctr - 1'b1;
                  if (r_drain_ctr <= DRAIN_W'(1))
                     r_state <= HALTED;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Directed-vector bench for hazard_ctrl_v2: instance A (LU_CYCLES=1, CNT_W=4)
// and instance B (LU_CYCLES=3, CNT_W=16) share stimulus; each test checks one.
module tb_hazard_ctrl_v2;

   logic       CLK = 1'b0;
   logic       RST;
   logic       ihit, dmem_req, dhit, halt_in, redirect, ex_load;
   logic [4:0] ex_rd, id_rs, id_rt;
   logic       id_use_rs, id_use_rt;

   logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush;
   logic        a_exmem_en, a_memwb_bubble, a_halted;
   logic [3:0]  a_stall_cnt, a_flush_cnt;
   logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush;
   logic        b_exmem_en, b_memwb_bubble, b_halted;
   logic [15:0] b_stall_cnt, b_flush_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   hazard_ctrl_v2 #(.REG_W(5), .LU_CYCLES(1), .DRAIN_CYCLES(3), .CNT_W(4)) u_dut_a (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
      .halt_in(halt_in), .redirect(redirect), .ex_load(ex_load), .ex_rd(ex_rd),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
      .idex_en(a_idex_en), .idex_flush(a_idex_flush), .exmem_en(a_exmem_en),
      .memwb_bubble(a_memwb_bubble), .halted(a_halted),
      .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
   );

   hazard_ctrl_v2 #(.REG_W(5), .LU_CYCLES(3), .DRAIN_CYCLES(3), .CNT_W(16)) u_dut_b (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
      .halt_in(halt_in), .redirect(redirect), .ex_load(ex_load), .ex_rd(ex_rd),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
      .idex_en(b_idex_en), .idex_flush(b_idex_flush), .exmem_en(b_exmem_en),
      .memwb_bubble(b_memwb_bubble), .halted(b_halted),
      .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   task automatic idle();
      ihit      = 1'b1;
      dmem_req  = 1'b0;
      dhit      = 1'b0;
      halt_in   = 1'b0;
      redirect  = 1'b0;
      ex_load   = 1'b0;
      ex_rd     = 5'd0;
      id_rs     = 5'd0;
      id_rt     = 5'd0;
      id_use_rs = 1'b0;
      id_use_rt = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      idle();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic lw_hazard_rs3();
      ex_load   = 1'b1;
      ex_rd     = 5'd3;
      id_rs     = 5'd3;
      id_use_rs = 1'b1;
   endtask

   initial begin
      idle();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      #1;
      // Reset state and idle RUN outputs
      chk("rst_halted_a", 32'(a_halted), 0);
      chk("rst_halted_b", 32'(b_halted), 0);
      chk("rst_stall_a", 32'(a_stall_cnt), 0);
      chk("rst_flush_b", 32'(b_flush_cnt), 0);
      chk("run_pc_en", 32'(a_pc_en), 1);
      chk("run_ifid_flush", 32'(a_ifid_flush), 0);
      chk("run_idex_flush", 32'(a_idex_flush), 0);

      // Load-use, LU_CYCLES=1: one stall cycle
      do_reset();
      lw_hazard_rs3();
      #1;
      chk("lu1_pc_en", 32'(a_pc_en), 0);
      chk("lu1_ifid_en", 32'(a_ifid_en), 0);
      chk("lu1_idex_flush", 32'(a_idex_flush), 1);
      chk("lu1_exmem_en", 32'(a_exmem_en), 1);
      tick();
      idle();
      #1;
      chk("lu1_after_pc_en", 32'(a_pc_en), 1);
      chk("lu1_stall_cnt", 32'(a_stall_cnt), 1);

      // Load-use, LU_CYCLES=3: three stall cycles then RUN
      do_reset();
      lw_hazard_rs3();
      #1;
      chk("lu3_c0_pc_en", 32'(b_pc_en), 0);
      tick();
      idle();
      #1;
      chk("lu3_c1_pc_en", 32'(b_pc_en), 0);
      chk("lu3_c1_idex_flush", 32'(b_idex_flush), 1);
      tick();
      #1;
      chk("lu3_c2_pc_en", 32'(b_pc_en), 0);
      tick();
      #1;
      chk("lu3_c3_pc_en", 32'(b_pc_en), 1);
      chk("lu3_stall_cnt", 32'(b_stall_cnt), 3);

      // r0 destination and source-use qualifiers
      ex_load = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
      #1;
      chk("r0_no_stall_a", 32'(a_pc_en), 1);
      chk("r0_no_stall_b", 32'(b_pc_en), 1);
      ex_rd = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_use_rs = 1'b1; id_use_rt = 1'b0;
      #1;
      chk("rt_unused_no_stall", 32'(a_pc_en), 1);
      id_use_rt = 1'b1;
      #1;
      chk("rt_used_stall", 32'(a_pc_en), 0);
      ihit = 1'b0;
      #1;
      chk("lu_over_ihit_ifid_en", 32'(a_ifid_en), 0);
      chk("lu_over_ihit_ifid_flush", 32'(a_ifid_flush), 0);

      // Redirect during a 4-cycle data-memory wait, applied on dhit
      do_reset();
      dmem_req = 1'b1; dhit = 1'b0; redirect = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("mw_pc_en", 32'(a_pc_en), 0);
         chk("mw_exmem_en", 32'(a_exmem_en), 0);
         chk("mw_bubble", 32'(a_memwb_bubble), 1);
         chk("mw_no_flush", 32'(a_ifid_flush), 0);
         tick();
      end
      redirect = 1'b0; dhit = 1'b1;
      #1;
      chk("mw_rel_ifid_flush", 32'(a_ifid_flush), 1);
      chk("mw_rel_idex_flush", 32'(a_idex_flush), 1);
      chk("mw_rel_pc_en", 32'(a_pc_en), 1);
      tick();
      idle();
      #1;
      chk("mw_pend_cleared", 32'(a_ifid_flush), 0);
      chk("mw_flush_cnt", 32'(a_flush_cnt), 1);
      chk("mw_stall_cnt", 32'(a_stall_cnt), 4);

      // Redirect in the 2nd LU_STALL cycle aborts the stall
      do_reset();
      lw_hazard_rs3();
      tick();
      idle();
      #1;
      chk("lur_c1_pc_en", 32'(b_pc_en), 0);
      tick();
      redirect = 1'b1;
      #1;
      chk("lur_c2_ifid_flush", 32'(b_ifid_flush), 1);
      chk("lur_c2_idex_flush", 32'(b_idex_flush), 1);
      chk("lur_c2_pc_en", 32'(b_pc_en), 1);
      tick();
      idle();
      #1;
      chk("lur_c3_pc_en", 32'(b_pc_en), 1);
      chk("lur_flush_cnt", 32'(b_flush_cnt), 1);
      chk("lur_stall_cnt", 32'(b_stall_cnt), 2);

      // Redirect outranks halt_in
      do_reset();
      redirect = 1'b1; halt_in = 1'b1;
      #1;
      chk("rvh_ifid_flush", 32'(a_ifid_flush), 1);
      chk("rvh_pc_en", 32'(a_pc_en), 1);
      tick();
      idle();
      #1;
      chk("rvh_no_drain", 32'(a_pc_en), 1);

      // Halt drain: 3 non-wait DRAIN cycles plus one wait cycle, then HALTED
      do_reset();
      halt_in = 1'b1;
      #1;
      chk("h_t0_pc_en", 32'(a_pc_en), 0);
      chk("h_t0_ifid_flush", 32'(a_ifid_flush), 1);
      tick();
      idle();
      redirect = 1'b1;
      #1;
      chk("h_t1_pc_en", 32'(a_pc_en), 0);
      chk("h_t1_idex_en", 32'(a_idex_en), 1);
      chk("h_t1_redir_ignored", 32'(a_idex_flush), 0);
      tick();
      redirect = 1'b0; dmem_req = 1'b1;
      #1;
      chk("h_t2_bubble", 32'(a_memwb_bubble), 1);
      chk("h_t2_exmem_en", 32'(a_exmem_en), 0);
      tick();
      idle();
      #1;
      chk("h_t3_halted", 32'(a_halted), 0);
      tick();
      #1;
      chk("h_t4_halted", 32'(a_halted), 0);
      tick();
      #1;
      chk("h_t5_halted", 32'(a_halted), 1);
      chk("h_t5_exmem_en", 32'(a_exmem_en), 0);
      redirect = 1'b1;
      tick();
      tick();
      #1;
      chk("h_hold_halted", 32'(a_halted), 1);
      chk("h_hold_flush_cnt", 32'(a_flush_cnt), 0);
      chk("h_stall_cnt", 32'(a_stall_cnt), 5);
      do_reset();
      #1;
      chk("h_rst_halted", 32'(a_halted), 0);
      chk("h_rst_stall_cnt", 32'(a_stall_cnt), 0);

      // Fetch miss outputs and stall counter saturation (CNT_W=4 in A)
      do_reset();
      ihit = 1'b0;
      #1;
      chk("imiss_pc_en", 32'(a_pc_en), 0);
      chk("imiss_ifid_flush", 32'(a_ifid_flush), 1);
      chk("imiss_idex_en", 32'(a_idex_en), 1);
      for (int i = 0; i < 21; i++) tick();
      chk("sat_stall_cnt_a", 32'(a_stall_cnt), 15);
      chk("nosat_stall_cnt_b", 32'(b_stall_cnt), 21);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_v2.md
Name: hazard_ctrl_v2

Overview:
Second-generation pipeline hazard controller for the 5-stage MIPS core. It replaces the purely combinational hazard logic with a registered controller. The controller adds:
- a configurable load-use stall length
- r0-aware dependency checks
- redirects deferred across data-memory waits
- a halt drain sequence
- saturating performance counters

It sits beside the datapath and drives every pipeline-latch enable, flush and bubble.

Parameters:
REG_W, 5, register-address width
LU_CYCLES, 1, stall cycles inserted per load-use hazard (1..7)
DRAIN_CYCLES, 3, cycles after halt detection before halted asserts (lets EX/MEM/WB retire)
CNT_W, 16, performance-counter width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
ihit  in  1  instruction fetch complete this cycle
dmem_req  in  1  MEM stage has dREN or dWEN asserted
dhit  in  1  data access complete this cycle
halt_in  in  1  halt opcode has reached MEM
redirect  in  1  EX resolved a taken branch/jump/jr (PC must change, younger ops squashed)
ex_load  in  1  ID/EX holds a load
ex_rd  in  REG_W  ID/EX load destination
id_rs  in  REG_W  IF/ID source rs
id_rt  in  REG_W  IF/ID source rt
id_use_rs  in  1  IF/ID instruction reads rs
id_use_rt  in  1  IF/ID instruction reads rt
pc_en  out  1  PC may update
ifid_en  out  1  IF/ID latch enable
ifid_flush  out  1  IF/ID loads NOP
idex_en  out  1  ID/EX latch enable
idex_flush  out  1  ID/EX loads NOP
exmem_en  out  1  EX/MEM latch enable
memwb_bubble  out  1  MEM/WB loads NOP
halted  out  1  core halted
stall_cnt  out  CNT_W  cycles with pc_en=0 (excluding HALTED)
flush_cnt  out  CNT_W  redirect flushes applied

Behaviour:
- States: RUN, LU_STALL, DRAIN, HALTED.
- Registers: state, lu_ctr (3b), drain_ctr, redir_pend, counters.
- Outputs are combinational from registered state plus inputs.
- On RST (sampled at the edge): state=RUN, lu_ctr=0, drain_ctr=0, redir_pend=0, both counters=0. halted=0 the cycle after.
- mem_wait = dmem_req & ~dhit. It is checked in RUN/LU_STALL/DRAIN and has the highest priority after RST:
  - pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1.
  - No state change.
  - A redirect seen during mem_wait sets redir_pend=1.
- eff_redir = redirect | redir_pend, evaluated only when ~mem_wait:
  - ifid_flush=idex_flush=1, pc_en=1, all enables 1.
  - Clear redir_pend. flush_cnt+1 (saturating).
  - In LU_STALL: abort to RUN with lu_ctr=0; the redirect wins.
- lu_hit = ex_load & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- RUN, no mem_wait, no eff_redir, lu_hit:
  - pc_en=0, ifid_en=0, idex_flush=1 (bubble), exmem_en=1.
  - If LU_CYCLES>1: go to LU_STALL with lu_ctr=LU_CYCLES-1.
- LU_STALL: same outputs as lu_hit. Decrement lu_ctr; at 1→0, return to RUN. lu_hit is not re-evaluated in LU_STALL.
- RUN, ~ihit (no higher event): pc_en=0, ifid_flush=1, other enables 1.
- halt_in in RUN/LU_STALL (no mem_wait):
  - Go to DRAIN, drain_ctr=DRAIN_CYCLES.
  - From then on pc_en=0 and ifid_flush=1 permanently; later stages keep advancing.
  - drain_ctr decrements per non-mem_wait cycle.
  - At 0 go to HALTED: all enables 0, halted=1.
  - Only RST leaves HALTED. redirect is ignored in DRAIN/HALTED.
- stall_cnt increments each cycle pc_en=0 while state≠HALTED. Both counters saturate at all-ones; no wrap.
- Priority: RST > mem_wait > eff_redir > halt_in > lu_hit/LU_STALL > ~ihit > normal (all enables 1, flushes 0).

Test Plan:
- lw $3 in EX, IF/ID add reads rs=3, LU_CYCLES=1 → exactly 1 cycle with pc_en=0, idex_flush=1; stall_cnt=1.
- LU_CYCLES=3, same hazard → pc_en=0 for 3 consecutive cycles, then RUN. Repeat with ex_rd=0 → no stall.
- redirect asserted while dmem_req=1, dhit=0 for 4 cycles → enables 0 for 4 cycles, no flush; flush pulse in the dhit cycle; flush_cnt=1.
- LU_CYCLES=3; redirect in the 2nd LU_STALL cycle → flush that cycle, state RUN, pc_en=1 next cycle.
- halt_in with DRAIN_CYCLES=3 and one mem_wait cycle inside the drain → halted rises 4 cycles later; RST then clears halted and the counters.
- Force 2^CNT_W+5 stall cycles (CNT_W=4) → stall_cnt holds 15.
